// File: rtl/psr_cond_if.sv
// Query/response handshake bundle for psr_cond_unit.
interface psr_cond_if;
  logic       req_valid;
  logic [3:0] req_cond;
  logic       req_ready;
  logic       rsp_valid;
  logic       rsp_true;
  logic [3:0] rsp_cond;
  logic       rsp_ready;

  modport master (
    output req_valid, req_cond, rsp_ready,
    input  req_ready, rsp_valid, rsp_true, rsp_cond
  );

  modport slave (
    input  req_valid, req_cond, rsp_ready,
    output req_ready, rsp_valid, rsp_true, rsp_cond
  );
endinterface

// File: rtl/psr_cond_unit.sv
// Processor status register {Z,C,F,N,L} with a pipelined condition-code evaluator.
// Optional PSR_BYPASS_EN: queries see same-cycle PSR writes (per-bit merge).
module psr_cond_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  flags_in,
  input  logic [4:0]  flags_we,
  output logic [4:0]  psr,
  psr_cond_if.slave   bus
);

  localparam int unsigned Z_B = 4;
  localparam int unsigned C_B = 3;
  localparam int unsigned F_B = 2;
  localparam int unsigned N_B = 1;
  localparam int unsigned L_B = 0;

  // Condition codes come in complementary pairs; cond[0] inverts the pair's base test.
  typedef enum logic [2:0] {
    PAIR_Z  = 3'd0,
    PAIR_C  = 3'd1,
    PAIR_L  = 3'd2,
    PAIR_N  = 3'd3,
    PAIR_F  = 3'd4,
    PAIR_LO = 3'd5,
    PAIR_LT = 3'd6,
    PAIR_UC = 3'd7
  } pair_e;

  logic [4:0] r_psr;
  logic       r_rsp_valid;
  logic       r_rsp_true;
  logic [3:0] r_rsp_cond;

  logic [4:0] w_merged;
  logic [4:0] w_eval;
  logic       w_accept;
  logic       w_base;
  logic       w_cond_true;
  pair_e      w_pair;

  assign w_merged = (flags_we & flags_in) | (~flags_we & r_psr);

`ifdef PSR_BYPASS_EN
  assign w_eval = w_merged;
`else
  assign w_eval = r_psr;
`endif

  assign bus.req_ready = !r_rsp_valid || bus.rsp_ready;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_pair        = pair_e'(bus.req_cond[3:1]);

  always_comb begin
    w_base = 1'b0;
    case (w_pair)
      PAIR_Z:  w_base = w_eval[Z_B];
      PAIR_C:  w_base = w_eval[C_B];
      PAIR_L:  w_base = w_eval[L_B];
      PAIR_N:  w_base = w_eval[N_B];
      PAIR_F:  w_base = w_eval[F_B];
      PAIR_LO: w_base = !w_eval[L_B] && !w_eval[Z_B];
      PAIR_LT: w_base = !w_eval[N_B] && !w_eval[Z_B];
      PAIR_UC: w_base = 1'b1;
      default: w_base = 1'b0;
    endcase
    w_cond_true = w_base ^ bus.req_cond[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_psr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_true  <= 1'b0;
      r_rsp_cond  <= '0;
    end else begin
      r_psr <= w_merged;
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_true  <= w_cond_true;
        r_rsp_cond  <= bus.req_cond;
      end else if (bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign psr          = r_psr;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_true  = r_rsp_true;
  assign bus.rsp_cond  = r_rsp_cond;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Scoreboard bench for psr_cond_unit: driver pushes expected responses, monitor pops and compares.
module tb_psr_cond_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] flags_in;
  logic [4:0] flags_we;
  logic [4:0] psr;

  psr_cond_if bus ();

  psr_cond_unit dut (
    .clk      (clk),
    .reset    (reset),
    .flags_in (flags_in),
    .flags_we (flags_we),
    .psr      (psr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [4:0] m_psr   = '0;
  logic       m_valid = 1'b0;
  logic       m_known = 1'b0;
  logic [4:0] q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Flag order {Z,C,F,N,L}; straight 16-entry condition table.
  function automatic logic cond_model(input logic [4:0] f, input logic [3:0] c);
    logic z, cy, fl, n, l;
    z = f[4]; cy = f[3]; fl = f[2]; n = f[1]; l = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return fl;
      4'd9:  return !fl;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input logic rst, input logic [4:0] fi, input logic [4:0] fw,
                      input logic rv, input logic [3:0] rc, input logic rr);
    logic       exp_ready;
    logic       acc;
    logic [4:0] ev;
    reset         = rst;
    flags_in      = fi;
    flags_we      = fw;
    bus.req_valid = rv;
    bus.req_cond  = rc;
    bus.rsp_ready = rr;
    @(negedge clk);
    exp_ready = !m_valid || rr;
    if (m_known) begin
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("psr", 32'(psr), 32'(m_psr));
    end
    acc = rv && exp_ready;
    ev  = m_psr;
`ifdef PSR_BYPASS_EN
    for (int i = 0; i < 5; i++) if (fw[i]) ev[i] = fi[i];
`endif
    @(posedge clk);
    if (rst) begin
      m_psr   = '0;
      m_valid = 1'b0;
      m_known = 1'b1;
      q.delete();
    end else begin
      for (int i = 0; i < 5; i++) if (fw[i]) m_psr[i] = fi[i];
      if (acc) q.push_back({cond_model(ev, rc), rc});
      m_valid = acc || (m_valid && !rr);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      check("rsp_valid", 32'(bus.rsp_valid), 32'(q.size() != 0));
      if (bus.rsp_valid && q.size() != 0) begin
        check("rsp_true", 32'(bus.rsp_true), 32'(q[0][4]));
        check("rsp_cond", 32'(bus.rsp_cond), 32'(q[0][3:0]));
        if (bus.rsp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1'b1, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b1);
    step(1'b0, 5'b11111, 5'b00000, 1'b1, 4'd14, 1'b1);  // UC, write masked off
    step(1'b0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b1);

    step(1'b0, 5'b01010, 5'b11111, 1'b0, 4'd0, 1'b1);
    step(1'b0, 5'b00000, 5'b00000, 1'b1, 4'd2, 1'b1);
    step(1'b0, 5'b00000, 5'b00000, 1'b1, 4'd6, 1'b1);
    step(1'b0, 5'b00000, 5'b00000, 1'b1, 4'd0, 1'b1);
    step(1'b0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b1);

    step(1'b0, 5'b00000, 5'b10011, 1'b0, 4'd0, 1'b1);
    step(1'b0, 5'b00000, 5'b00000, 1'b1, 4'd10, 1'b1);
    step(1'b0, 5'b00000, 5'b00000, 1'b1, 4'd11, 1'b1);
    step(1'b0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b1);

    step(1'b0, 5'b00000, 5'b00000, 1'b1, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 5'b00000, 5'b00000, 1'b1, 4'd4, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 5'b00000, 5'b00000, 1'b1, 4'(5 + i), 1'b1);
    step(1'b0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b1);

    step(1'b0, 5'b10000, 5'b10000, 1'b1, 4'd0, 1'b1);  // same-cycle write vs query
    step(1'b0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b1);

    step(1'b0, 5'b11111, 5'b11111, 1'b1, 4'd14, 1'b0);
    step(1'b1, 5'b10101, 5'b11111, 1'b1, 4'd14, 1'b0);
    step(1'b0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b1);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), 5'($urandom), 5'($urandom),
           1'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));

    step(1'b0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b1);
    step(1'b0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b1);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
